// File: rtl/spi_reg_slave.sv
// ---------------------------------------------------------------------------
// spi_reg_slave
//
// SPI target that turns fixed-length frames into register accesses. It sits
// behind the pad synchronizers, so spi_cs_n/spi_clk/spi_mosi and the mode
// pins arrive already in the clk domain and are oversampled here.
//
// Frame layout, MSB first:
//   cmd[7]   rw   (1 = write, 0 = read)
//   cmd[6]   bank (0 = config, 1 = status)
//   cmd[5:0] address field; only values below NUM_REGS hit a register
//   then WIDTH data bits
//
// Handshake/timing contract: there is no valid/ready pair on this block. The
// SPI side is qualified only by spi_cs_n low plus clock edges, and the user
// side sees a single-cycle wr_strobe in the cycle where the updated register
// value first appears on config_regs. ena low freezes every flop.
//
// Ports
//   clk          system clock, rising edge
//   rstb         asynchronous active-low reset
//   ena          clock enable for the whole block
//   mode         {cpol, cpha}, captured when spi_cs_n falls
//   spi_cs_n     synchronized chip select, active low
//   spi_clk      synchronized SPI clock
//   spi_mosi     synchronized MOSI
//   spi_miso     MISO toward the pad (registered)
//   config_regs  config bank, reg i at [i*WIDTH +: WIDTH]
//   status_regs  status bank, same packing, read-only over SPI
//   wr_strobe    one-cycle pulse when a config write commits
//   wr_addr      address of the last committed write
// ---------------------------------------------------------------------------
module spi_reg_slave #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  logic [1:0]                mode,
    input  logic                      spi_cs_n,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic [NUM_REGS*WIDTH-1:0] config_regs,
    input  logic [NUM_REGS*WIDTH-1:0] status_regs,
    output logic                      wr_strobe,
    output logic [ADDR_W-1:0]         wr_addr
);

    localparam int FRAME_LEN = 8 + WIDTH;
    localparam int CNT_W     = 6;
    // Data receive register only has to remember WIDTH-1 bits; the last bit
    // is taken straight from spi_mosi on the committing edge.
    localparam int RXW       = (WIDTH > 1) ? WIDTH - 1 : 1;

    localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_LEN - 1);
    // Shifting starts only after the first shift edge following the load,
    // which lines MISO up for both CPHA settings.
    localparam logic [CNT_W-1:0] CNT_SHIFT_MIN = CNT_W'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sclk_q, sclk_d;
    logic                      cs_q, cs_d;
    logic [1:0]                mode_q, mode_d;
    logic [6:0]                cmd_sr_q, cmd_sr_d;
    logic [7:0]                cmd_q, cmd_d;
    logic [RXW-1:0]            rx_q, rx_d;
    logic [WIDTH-1:0]          tx_q, tx_d;
    logic                      miso_q, miso_d;
    logic [NUM_REGS*WIDTH-1:0] cfg_q, cfg_d;
    logic                      wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;

    // Edge detection against the registered copies.
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge;
    logic [7:0]       cmd_full;
    logic [WIDTH-1:0] rx_full;
    logic [WIDTH-1:0] rd_data;
    logic             wr_hit;

    assign sclk_rise = spi_clk & ~sclk_q;
    assign sclk_fall = ~spi_clk & sclk_q;
    assign cs_rise   = spi_cs_n & ~cs_q;
    assign cs_fall   = ~spi_cs_n & cs_q;

    // cpol == cpha samples on the rising edge, otherwise on the falling edge.
    assign sample_edge = (mode_q[1] == mode_q[0]) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode_q[1] == mode_q[0]) ? sclk_fall : sclk_rise;

    // Command byte as it stands including the bit arriving this cycle.
    assign cmd_full = {cmd_sr_q, spi_mosi};

    generate
        if (WIDTH > 1) begin : g_rx_wide
            assign rx_full = {rx_q, spi_mosi};
        end else begin : g_rx_one
            assign rx_full = spi_mosi;
        end
    endgenerate

    // Read mux, evaluated on the edge that completes the command byte.
    // Addresses at or above NUM_REGS (including non-zero reserved bits)
    // match nothing and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_full[5:0] == 6'(i)) begin
                rd_data = cmd_full[6] ? status_regs[i*WIDTH +: WIDTH]
                                      : cfg_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // A write lands only for rw=1, config bank, and an in-range address.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_q[5:0] == 6'(i)) begin
                wr_hit = 1'b1;
            end
        end
        wr_hit = wr_hit & cmd_q[7] & ~cmd_q[6];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mode_d      = mode_q;
        cmd_sr_d    = cmd_sr_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        cfg_d       = cfg_q;
        wr_strobe_d = wr_strobe_q;
        wr_addr_d   = wr_addr_q;

        if (ena) begin
            sclk_d      = spi_clk;
            cs_d        = spi_cs_n;
            wr_strobe_d = 1'b0;

            // Chip select release beats any clock edge seen in the same cycle,
            // so a frame cut short on its final bit commits nothing.
            if (cs_rise) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                miso_d  = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        miso_d = 1'b0;
                        if (cs_fall) begin
                            state_d = S_CMD;
                            cnt_d   = '0;
                            mode_d  = mode;
                        end
                    end

                    S_CMD: begin
                        miso_d = 1'b0;
                        if (sample_edge) begin
                            cnt_d    = cnt_q + CNT_W'(1);
                            cmd_sr_d = cmd_full[6:0];
                            if (cnt_q == CNT_CMD_LAST) begin
                                state_d = S_DATA;
                                cmd_d   = cmd_full;
                                // Writes shift out zeros.
                                tx_d    = cmd_full[7] ? '0 : rd_data;
                                miso_d  = tx_d[WIDTH-1];
                            end
                        end
                    end

                    S_DATA: begin
                        if (sample_edge) begin
                            cnt_d = cnt_q + CNT_W'(1);
                            rx_d  = rx_full[RXW-1:0];
                            if (cnt_q == CNT_DATA_LAST) begin
                                state_d = S_DONE;
                                miso_d  = 1'b0;
                                if (wr_hit) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (cmd_q[5:0] == 6'(i)) begin
                                            cfg_d[i*WIDTH +: WIDTH] = rx_full;
                                        end
                                    end
                                    wr_addr_d   = cmd_q[ADDR_W-1:0];
                                    wr_strobe_d = 1'b1;
                                end
                            end
                        end else if (shift_edge && (cnt_q >= CNT_SHIFT_MIN)) begin
                            tx_d   = tx_q << 1;
                            miso_d = tx_d[WIDTH-1];
                        end
                    end

                    S_DONE: begin
                        miso_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            mode_q      <= 2'b00;
            cmd_sr_q    <= '0;
            cmd_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            cfg_q       <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mode_q      <= mode_d;
            cmd_sr_q    <= cmd_sr_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            cfg_q       <= cfg_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi_miso    = miso_q;
    assign config_regs = cfg_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Directed bench for spi_reg_slave with NUM_REGS=8, WIDTH=8. A table of SPI
// frames (mode, bit count, frame bits, abort point) is played through a
// bit-level SPI master task; after each frame the config bank, wr_addr,
// strobe count and MISO read data are compared with hand-computed values.
// Reset-in-frame and ena=0 hold are covered by short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_spi_reg_slave;

    localparam int NUM_REGS = 8;
    localparam int WIDTH    = 8;
    localparam int HALF     = 4;   // SPI half period in clk cycles
    localparam int NONE     = 99;  // stop_at value meaning "full frame"
    localparam int NV       = 18;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rstb;
    logic ena;
    logic [1:0] mode;
    logic spi_cs_n, spi_clk, spi_mosi;
    logic spi_miso;
    logic [NUM_REGS*WIDTH-1:0] config_regs;
    logic [NUM_REGS*WIDTH-1:0] status_regs;
    logic wr_strobe;
    logic [2:0] wr_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_reg_slave #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [7:0] model_cfg [NUM_REGS];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_bank();
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < NUM_REGS; i++) b[i*8 +: 8] = model_cfg[i];
        return b;
    endfunction

    // ---------------- driver ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Plays nbits of frame (MSB first) in the given SPI mode. Stops before
    // bit stop_at; cs_last raises cs_n together with the final sample edge;
    // keep_cs leaves cs_n low on return. cap collects MISO as the master
    // samples it, one bit per sample edge.
    task automatic spi_xfer(input logic [1:0] m, input int nbits, input logic [31:0] frame,
                            input int stop_at, input bit cs_last, input bit keep_cs,
                            output logic [31:0] cap);
        logic cpol, cpha, b, last;
        cpol = m[1];
        cpha = m[0];
        cap  = '0;
        @(negedge clk);
        mode     = m;
        spi_clk  = cpol;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(4);
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == stop_at) break;
            b    = frame[nbits-1-i];
            last = (i == nbits - 1);
            if (!cpha) begin
                spi_mosi = b;
                wait_clks(HALF);
                cap = {cap[30:0], spi_miso};
                spi_clk = ~cpol;
                if (cs_last && last) spi_cs_n = 1'b1;
                wait_clks(HALF);
                spi_clk = cpol;
            end else begin
                spi_clk  = ~cpol;
                spi_mosi = b;
                wait_clks(HALF);
                cap = {cap[30:0], spi_miso};
                spi_clk = cpol;
                if (cs_last && last) spi_cs_n = 1'b1;
                wait_clks(HALF);
            end
        end
        wait_clks(HALF);
        if (!keep_cs) spi_cs_n = 1'b1;
        wait_clks(4);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        int          nbits;
        logic [31:0] frame;
        int          stop_at;
        bit          cs_last;
        bit          is_rd;
        logic [7:0]  exp_rd;
        int          exp_strb;
        int          reg_idx;   // register whose model value is given next
        logic [7:0]  reg_val;
        logic [2:0]  exp_wa;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        logic [31:0] cap;
        int s0;

        // status bank: reg7..reg0
        status_regs = {8'h77, 8'h66, 8'h3C, 8'h44, 8'h33, 8'h22, 8'h99, 8'hE1};

        //           mode  bits frame         stop  csl  rd   exp_rd strb idx val    wa
        vecs[0]  = '{2'd0, 16, 32'h0000_83A5, NONE, 1'b0, 1'b0, 8'h00, 1, 3, 8'hA5, 3'd3};
        vecs[1]  = '{2'd3, 16, 32'h0000_0300, NONE, 1'b0, 1'b1, 8'hA5, 0, 3, 8'hA5, 3'd3};
        vecs[2]  = '{2'd1, 16, 32'h0000_4500, NONE, 1'b0, 1'b1, 8'h3C, 0, 5, 8'h00, 3'd3};
        vecs[3]  = '{2'd2, 16, 32'h0000_4500, NONE, 1'b0, 1'b1, 8'h3C, 0, 5, 8'h00, 3'd3};
        vecs[4]  = '{2'd1, 16, 32'h0000_C5FF, NONE, 1'b0, 1'b0, 8'h00, 0, 5, 8'h00, 3'd3};
        vecs[5]  = '{2'd0, 16, 32'h0000_8277, 12,   1'b0, 1'b0, 8'h00, 0, 2, 8'h00, 3'd3};
        vecs[6]  = '{2'd0, 16, 32'h0000_825A, NONE, 1'b0, 1'b0, 8'h00, 1, 2, 8'h5A, 3'd2};
        vecs[7]  = '{2'd2, 16, 32'h0000_8911, NONE, 1'b0, 1'b0, 8'h00, 0, 1, 8'h00, 3'd2};
        vecs[8]  = '{2'd3, 16, 32'h0000_0900, NONE, 1'b0, 1'b1, 8'h00, 0, 1, 8'h00, 3'd2};
        vecs[9]  = '{2'd0, 24, 32'h0087_C3FF, NONE, 1'b0, 1'b0, 8'h00, 1, 7, 8'hC3, 3'd7};
        vecs[10] = '{2'd1, 16, 32'h0000_8001, NONE, 1'b0, 1'b0, 8'h00, 1, 0, 8'h01, 3'd0};
        vecs[11] = '{2'd3, 16, 32'h0000_0200, NONE, 1'b0, 1'b1, 8'h5A, 0, 2, 8'h5A, 3'd0};
        vecs[12] = '{2'd1, 16, 32'h0000_0700, NONE, 1'b0, 1'b1, 8'hC3, 0, 7, 8'hC3, 3'd0};
        vecs[13] = '{2'd2, 16, 32'h0000_4000, NONE, 1'b0, 1'b1, 8'hE1, 0, 0, 8'h01, 3'd0};
        vecs[14] = '{2'd0, 16, 32'h0000_8466, NONE, 1'b1, 1'b0, 8'h00, 0, 4, 8'h00, 3'd0};
        vecs[15] = '{2'd1, 16, 32'h0000_8466, NONE, 1'b1, 1'b0, 8'h00, 0, 4, 8'h00, 3'd0};
        vecs[16] = '{2'd3, 16, 32'h0000_8466, NONE, 1'b0, 1'b0, 8'h00, 1, 4, 8'h66, 3'd4};
        vecs[17] = '{2'd0, 16, 32'h0000_4100, NONE, 1'b0, 1'b1, 8'h99, 0, 4, 8'h66, 3'd4};

        for (int i = 0; i < NUM_REGS; i++) model_cfg[i] = 8'h00;

        // ---------------- reset ----------------
        rstb = 1'b0; ena = 1'b1; mode = 2'b00;
        spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        wait_clks(3);
        check("reset config_regs", config_regs, 64'h0);
        check("reset spi_miso", 64'(spi_miso), 64'h0);
        check("reset wr_strobe", 64'(wr_strobe), 64'h0);
        check("reset wr_addr", 64'(wr_addr), 64'h0);
        rstb = 1'b1;
        wait_clks(3);

        // ---------------- table ----------------
        for (int v = 0; v < NV; v++) begin
            s0 = strobe_cnt;
            spi_xfer(vecs[v].mode, vecs[v].nbits, vecs[v].frame, vecs[v].stop_at,
                     vecs[v].cs_last, 1'b0, cap);
            model_cfg[vecs[v].reg_idx] = vecs[v].reg_val;
            check($sformatf("v%0d strobes", v), 64'(strobe_cnt - s0), 64'(vecs[v].exp_strb));
            check($sformatf("v%0d config_regs", v), config_regs, model_bank());
            check($sformatf("v%0d wr_addr", v), 64'(wr_addr), 64'(vecs[v].exp_wa));
            check($sformatf("v%0d miso idle", v), 64'(spi_miso), 64'h0);
            if (vecs[v].is_rd) begin
                check($sformatf("v%0d read data", v), 64'(cap[7:0]), 64'(vecs[v].exp_rd));
                check($sformatf("v%0d miso in cmd", v), 64'(cap[15:8]), 64'h0);
            end
        end

        // ---------------- ena=0 hold ----------------
        @(negedge clk);
        ena = 1'b0;
        s0 = strobe_cnt;
        spi_xfer(2'd0, 16, 32'h0000_8311, NONE, 1'b0, 1'b0, cap);
        check("ena0 config_regs", config_regs, model_bank());
        check("ena0 strobes", 64'(strobe_cnt - s0), 64'h0);
        check("ena0 wr_addr", 64'(wr_addr), 64'd4);
        @(negedge clk);
        ena = 1'b1;
        s0 = strobe_cnt;
        spi_xfer(2'd0, 16, 32'h0000_8312, NONE, 1'b0, 1'b0, cap);
        model_cfg[3] = 8'h12;
        check("ena1 config_regs", config_regs, model_bank());
        check("ena1 strobes", 64'(strobe_cnt - s0), 64'h1);
        check("ena1 wr_addr", 64'(wr_addr), 64'd3);

        // ---------------- reset mid-write ----------------
        s0 = strobe_cnt;
        spi_xfer(2'd0, 16, 32'h0000_8499, 12, 1'b0, 1'b1, cap);
        rstb = 1'b0;
        wait_clks(2);
        for (int i = 0; i < NUM_REGS; i++) model_cfg[i] = 8'h00;
        check("midrst config_regs", config_regs, 64'h0);
        check("midrst wr_addr", 64'(wr_addr), 64'h0);
        check("midrst spi_miso", 64'(spi_miso), 64'h0);
        check("midrst wr_strobe", 64'(wr_strobe), 64'h0);
        rstb = 1'b1;
        wait_clks(3);
        spi_cs_n = 1'b1;
        wait_clks(4);
        check("postrst config_regs", config_regs, 64'h0);
        check("postrst strobes", 64'(strobe_cnt - s0), 64'h0);
        s0 = strobe_cnt;
        spi_xfer(2'd1, 16, 32'h0000_8655, NONE, 1'b0, 1'b0, cap);
        model_cfg[6] = 8'h55;
        check("postrst write config_regs", config_regs, model_bank());
        check("postrst write strobes", 64'(strobe_cnt - s0), 64'h1);
        check("postrst write wr_addr", 64'(wr_addr), 64'd6);
        spi_xfer(2'd0, 16, 32'h0000_0600, NONE, 1'b0, 1'b0, cap);
        check("postrst read data", 64'(cap[7:0]), 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
